alu_slice_add_seq: RTL

- Multi-cycle adder/subtractor controller that time-shares one 4-bit CLA slice to form a WIDTH-bit sum, one nibble per clock, LSB nibble first.
- Sits beside the ALU as the low-area add/sub path for multi-cycle ops (address calc, wide accumulate).
- Owns operand capture, nibble sequencing, the inter-slice carry register, result assembly, flags and a valid/ready handshake on both sides.

---
 rtl/alu_slice_add_seq_if.sv | 28 ++
 rtl/alu_slice_add_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_slice_add_seq_if.sv
// rtl/alu_slice_add_seq_if.sv - request/result handshake bundle for the nibble-serial add/sub controller
interface alu_slice_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // requester / result consumer side
    modport master (
        output req_valid, a, b, sub, res_ready,
        input  req_ready, res_valid, sum, cout, ovf, zero
    );

    // arithmetic block side
    modport slave (
        input  req_valid, a, b, sub, res_ready,
        output req_ready, res_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/alu_slice_add_seq.sv
// rtl/alu_slice_add_seq.sv - multi-cycle add/sub that time-shares one 4-bit CLA slice, LSB nibble first
module alu_slice_add_seq_cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // carry lookahead across the four bit positions
    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module alu_slice_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    alu_slice_add_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW+1:0]  nib_base;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic [3:0]       sl_s;
    logic             sl_co;
    logic             accept;
    logic             last_pass;

    assign accept    = (state_q == IDLE) && bus.req_valid && !flush;
    assign last_pass = (state_q == RUN) && (idx_q == LAST_IDX);
    assign nib_base  = {idx_q, 2'b00};

    alu_slice_add_seq_cla4 u_slice (
        .x   (a_q[nib_base +: 4]),
        .y   (b_q[nib_base +: 4]),
        .cin (carry_q),
        .s   (sl_s),
        .co  (sl_co)
    );

    // merge the current slice result into its nibble so the final edge sees the whole sum
    always_comb begin
        sum_d                = sum_q;
        sum_d[nib_base +: 4] = sl_s;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: flush wins over every handshake, DONE waits for the consumer
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.req_valid) state_d = RUN;
                RUN:     if (idx_q == LAST_IDX) state_d = DONE;
                DONE:    if (bus.res_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // operand capture, nibble sequencing, carry chaining and flag generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (flush) begin
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            // subtraction is A + ~B + 1, the +1 riding in on the first carry
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= sum_d;
            carry_q <= sl_co;
            if (last_pass) begin
                cout_q <= sl_co;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_q <= (sum_d == '0);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
